// File: rtl/mem_access_pkg.sv
// Shared FSM state encoding and RV32 load/store funct3 codes for the memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction: picks byte/half by address offset and sign/zero extends.
module load_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between pipeline and a falling-edge data memory: one strobe cycle per access.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_t state, state_nxt;

  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;

  logic                  legal, misal, req_err;
  logic [DM_ADDRESS-1:0] addr_al;
  logic [DATA_W-1:0]     ld_data;

  // Request decode; only meaningful while IDLE.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~req_write;
      default:          legal = 1'b0;
    endcase
    misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    req_err = ~legal | misal;
`else
    req_err = ~legal;
`endif
    // Force natural alignment; in trap mode misaligned requests never strobe anyway.
    addr_al = req_addr;
    case (req_funct3[1:0])
      2'b01:   addr_al[0]   = 1'b0;
      2'b10:   addr_al[1:0] = 2'b00;
      default: addr_al      = req_addr;
    endcase
  end

  load_align u_load_align (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .word   (mem_rdata),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          f3_q    <= req_funct3;
          addr_q  <= addr_al;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= req_err;
        end
        S_LOAD:  rdata_q <= ld_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)        state_nxt = S_RESP;
          else if (req_write) state_nxt = S_STORE;
          else                state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        mem_rd    = 1'b1;
        state_nxt = S_RESP;
      end
      S_STORE: begin
        mem_wr    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory-side bus is zero whenever no strobe is active.
  always_comb begin
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = '0;
    if (mem_rd || mem_wr) mem_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
    if (mem_wr) begin
      case (f3_q[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_wstrb = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge word memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [128];

  mem_access_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory clocks on the falling edge, so read data is ready before the next rising edge.
  always @(negedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
    if (mem_wr) begin
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) mem[mem_addr[8:2]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request in the current cycle (N); returns at cycle N+1, req_valid dropped.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid  = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_xfer", 32'(rsp_valid), 32'd0);
  endtask

  // Complete load: checks strobe at N+1 and the response at N+2.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [8:0] a,
                         input logic [8:0] exp_addr, input logic [31:0] exp_data);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd1);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    step();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, exp_data);
    finish_rsp();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem_rdata  = 32'h0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 9'h0;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b0;
    #22;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_strobes", {30'h0, mem_rd, mem_wr}, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset_n = 1'b1;
    step();

    // SW then LW round trip
    issue(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    chk("sw_mem_wr", 32'(mem_wr), 32'd1);
    chk("sw_mem_rd", 32'(mem_rd), 32'd0);
    chk("sw_mem_addr", 32'(mem_addr), 32'h010);
    chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw_mem_wr_off", 32'(mem_wr), 32'd0);
    chk("sw_rsp_rdata", rsp_rdata, 32'h0);
    finish_rsp();
    do_load("lw", 3'b010, 9'h010, 9'h010, 32'hDEADBEEF);

    // SB into the top lane, then signed/unsigned byte loads
    issue(1'b1, 3'b000, 9'h013, 32'h000000A5);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_wdata_lane3", 32'(mem_wdata[31:24]), 32'hA5);
    chk("sb_mem_addr", 32'(mem_addr), 32'h010);
    step();
    finish_rsp();
    do_load("lb", 3'b000, 9'h013, 9'h010, 32'hFFFFFFA5);
    do_load("lbu", 3'b100, 9'h013, 9'h010, 32'h000000A5);
    do_load("lw_after_sb", 3'b010, 9'h010, 9'h010, 32'hA5ADBEEF);

    // SH into upper half
    issue(1'b1, 3'b001, 9'h022, 32'h0000BEEF);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata_hi", 32'(mem_wdata[31:16]), 32'hBEEF);
    step();
    finish_rsp();

    // Half loads from a preloaded word
    mem[4] = 32'h80011234;
    do_load("lh_hi", 3'b001, 9'h012, 9'h010, 32'hFFFF8001);
    do_load("lhu_hi", 3'b101, 9'h012, 9'h010, 32'h00008001);
    do_load("lh_lo", 3'b001, 9'h010, 9'h010, 32'h00001234);

    // Illegal funct3: response one cycle after accept, no strobe
    issue(1'b0, 3'b011, 9'h010, 32'h0);
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_rsp_err", 32'(rsp_err), 32'd1);
    chk("ill_no_strobe", {30'h0, mem_rd, mem_wr}, 32'd0);
    chk("ill_rdata", rsp_rdata, 32'h0);
    finish_rsp();
    issue(1'b1, 3'b100, 9'h010, 32'h1);
    chk("ill_store_err", 32'(rsp_err), 32'd1);
    chk("ill_store_no_wr", 32'(mem_wr), 32'd0);
    finish_rsp();

    // Misaligned word load
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 9'h011, 32'h0);
    chk("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mis_rsp_err", 32'(rsp_err), 32'd1);
    chk("mis_no_rd", 32'(mem_rd), 32'd0);
    finish_rsp();
`else
    do_load("mis_lw", 3'b010, 9'h011, 9'h010, 32'h80011234);
    do_load("mis_lhu", 3'b101, 9'h013, 9'h010, 32'h00008001);
`endif

    // Backpressure: response held 5 cycles, new requests ignored
    issue(1'b0, 3'b010, 9'h020, 32'h0);
    step();
    req_valid = 1'b1;
    req_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'hBEEF0000);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_no_strobe", {30'h0, mem_rd, mem_wr}, 32'd0);
      step();
    end
    req_valid = 1'b0;
    finish_rsp();
    chk("hold_idle_ready", 32'(req_ready), 32'd1);

    // Reset in the STORE cycle
    issue(1'b1, 3'b010, 9'h030, 32'h12345678);
    chk("rst_store_wr", 32'(mem_wr), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_store_wr_off", 32'(mem_wr), 32'd0);
    chk("rst_store_wstrb", 32'(mem_wstrb), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("rst_store_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_store_ready", 32'(req_ready), 32'd1);
    step();
    chk("rst_store_no_rsp2", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width toward data memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width, fixed at 32.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  1  pipeline presents a memory request.
REQ-006 SHALL have port req_ready  out  1  unit accepts a request this cycle.
REQ-007 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  in  3  instruction bits 14:12.
REQ-009 SHALL have port req_addr  in  DM_ADDRESS  byte address (ALU result LSBs).
REQ-010 SHALL have port req_wdata  in  DATA_W  store data, right-justified.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  pipeline consumes the response.
REQ-013 SHALL have port rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  out  1  misaligned or unsupported access.
REQ-015 SHALL have port mem_rd  out  1  read strobe to data memory.
REQ-016 SHALL have port mem_wr  out  1  write strobe to data memory.
REQ-017 SHALL have port mem_addr  out  DM_ADDRESS  word-aligned address (bits 1:0 = 0).
REQ-018 SHALL have port mem_wstrb  out  4  byte-lane enables for writes.
REQ-019 SHALL have port mem_wdata  out  DATA_W  lane-shifted store data.
REQ-020 SHALL have port mem_rdata  in  DATA_W  full word from memory, valid at end of the mem_rd cycle (memory clocks on falling edge).

Function
REQ-021 SHALL implement FSM IDLE, LOAD, STORE, RESP; req_ready = 1 only in IDLE.
REQ-022 SHALL in IDLE on req_valid latch write/funct3/addr/wdata; go LOAD (load), STORE (store), or RESP with rsp_err=1 (illegal).
REQ-023 SHALL accept loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010; all other funct3 illegal, no memory strobe.
REQ-024 SHALL in LOAD drive mem_rd=1 for exactly one cycle, capture extended data at cycle end, go RESP.
REQ-025 SHALL in STORE drive mem_wr=1 for exactly one cycle with wstrb SB 0001<<a[1:0], SH 0011<<a[1:0], SW 1111; mem_wdata = byte/half replicated or shifted into its lane; go RESP.
REQ-026 SHALL extract load lanes by a[1:0]; sign-extend LB/LH, zero-extend LBU/LHU.
REQ-027 SHALL latency: request accepted cycle N, strobe cycle N+1, rsp_valid cycle N+2; illegal request rsp_valid at N+1.
REQ-028 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; transfer cycle returns to IDLE (no back-to-back accept in same cycle).
REQ-029 SHALL keep mem_rd and mem_wr never both 1, and both 0 outside LOAD/STORE.
REQ-030 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-031 SHALL on reset_n low asynchronously enter IDLE; rsp_valid, rsp_err, mem_rd, mem_wr, mem_wstrb = 0; rsp_rdata, mem_addr, mem_wdata = 0.
REQ-032 SHALL on reset during STORE deassert mem_wr immediately; no response issued for the aborted request.

Configuration
REQ-033 SHALL with MEM_ACCESS_MISALIGN_TRAP_EN defined flag LW with a[1:0]!=0 and LH/LHU/SH with a[0]!=0 as rsp_err=1, no strobe.
REQ-034 SHALL without it force alignment (clear a[1:0] for word, a[0] for half) and complete normally with rsp_err=0.

Structure
REQ-035 SHALL place funct3 constants and the FSM state enum in package mem_access_pkg.
REQ-036 SHALL put lane extraction/extension in sub-module load_align (combinational).

Verification
REQ-037 SW addr 0x010 data 0xDEADBEEF -> mem_wr at N+1, mem_addr 0x010, wstrb 1111; LW 0x010 -> rsp_rdata 0xDEADBEEF at N+2.
REQ-038 SB addr 0x013 data 0x000000A5 -> wstrb 1000, mem_wdata[31:24]=0xA5; LB 0x013 -> 0xFFFFFFA5, LBU -> 0x000000A5.
REQ-039 LH addr 0x012, mem_rdata 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
REQ-040 With trap macro, LW addr 0x011 -> rsp_err=1 at N+1, no mem_rd; without macro -> mem_addr 0x010, rsp_err=0.
REQ-041 Load with rsp_ready low 5 cycles -> rsp_valid/rsp_rdata held stable, req_ready 0, no extra mem_rd.
REQ-042 reset_n low during STORE cycle -> mem_wr 0 at once, IDLE, rsp_valid 0 after release.
